// File: rtl/flp_div_pkg.sv
// flp_div_pkg: shared types and constants for the divider request sequencer.
//   state_t        sequencer FSM states
//   QNAN           quotient reported when the watchdog forces completion
//   FLG_*          bit positions inside the 4-bit result flag vector
//   EXP_*/MAN_*    IEEE-754 single-precision field slices
package flp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLG_NAN  = 3;
  localparam int FLG_INF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DZ   = 0;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam int MAN_LSB = 0;

  localparam logic [7:0] EXP_MAX = 8'hFF;

endpackage

// File: rtl/flp_classify.sv
// flp_classify: combinational IEEE-754 single-precision classifier.
//   val      in  32  operand to classify
//   is_nan   out 1   exponent all ones, mantissa non-zero
//   is_inf   out 1   exponent all ones, mantissa zero
//   is_zero  out 1   exponent and mantissa zero (either sign)
module flp_classify
  import flp_div_pkg::*;
(
  input  logic [31:0] val,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero
);

  logic [EXP_MSB-EXP_LSB:0] exp_f;
  logic [MAN_MSB-MAN_LSB:0] man_f;
  logic                     sign_unused;

  assign exp_f       = val[EXP_MSB:EXP_LSB];
  assign man_f       = val[MAN_MSB:MAN_LSB];
  // The sign never affects the class.
  assign sign_unused = val[31];

  assign is_nan  = (exp_f == EXP_MAX) && (man_f != '0);
  assign is_inf  = (exp_f == EXP_MAX) && (man_f == '0);
  assign is_zero = (exp_f == '0)      && (man_f == '0);

endmodule

// File: rtl/flp_div_seq.sv
// flp_div_seq: valid/ready request sequencer in front of a multi-cycle
// floating-point divider. Captures an operand pair, restarts the divider,
// waits for done (bounded by a watchdog) and holds the classified quotient
// until the consumer takes it.
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid/in_ready, in_a/in_b      operand handshake (IEEE-754 single)
//   div_a/div_b  registered operands to the divider
//   div_rst      active-high divider reset/restart
//   div_q/div_done                    divider quotient and completion
//   out_valid/out_ready, out_q        result handshake
//   out_flags    {nan, inf, zero, dz}
//   out_timeout  result was forced by the watchdog
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair, divider held in reset
// START | one-cycle divider restart with new operands applied
// ARM   | divider released, watchdog cleared, done ignored (may be stale)
// BUSY  | waiting for done, watchdog counting
// DONE  | result held until the consumer accepts it
module flp_div_seq
  import flp_div_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_rst,
  input  logic [31:0] div_q,
  input  logic        div_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [3:0]  out_flags,
  output logic        out_timeout
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dz_q;
  logic             accept;
  logic             cnt_hit;

  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic q_nan, q_inf, q_zero;
  logic in_dz;
  logic [3:0] done_flags;
  logic [3:0] to_flags;

  flp_classify u_cls_a (.val(in_a),  .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
  flp_classify u_cls_b (.val(in_b),  .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));
  flp_classify u_cls_q (.val(div_q), .is_nan(q_nan), .is_inf(q_inf), .is_zero(q_zero));

  logic cls_unused;
  assign cls_unused = a_inf ^ b_nan ^ b_inf;

  // 0/0 and NaN/0 are invalid operations, not divide-by-zero.
  assign in_dz   = b_zero & ~a_zero & ~a_nan;
  assign accept  = in_valid & in_ready;
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    done_flags           = '0;
    done_flags[FLG_NAN]  = q_nan;
    done_flags[FLG_INF]  = q_inf;
    done_flags[FLG_ZERO] = q_zero;
    done_flags[FLG_DZ]   = dz_q;
    to_flags             = '0;
    to_flags[FLG_NAN]    = 1'b1;
    to_flags[FLG_DZ]     = dz_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // in_ready in DONE follows out_ready combinationally so a new pair can be
  // taken in the same cycle the result leaves.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    div_rst   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        div_rst  = 1'b1;
        if (in_valid) state_d = ST_START;
      end
      ST_START: begin
        div_rst = 1'b1;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (div_done || cnt_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? ST_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_ARM) begin
      cnt_q <= '0;
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_a <= '0;
      div_b <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      div_a <= in_a;
      div_b <= in_b;
      dz_q  <= in_dz;
    end
  end

  // div_done takes priority over a coinciding watchdog expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_flags   <= '0;
      out_timeout <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      if (div_done) begin
        out_q       <= div_q;
        out_flags   <= done_flags;
        out_timeout <= 1'b0;
      end else if (cnt_hit) begin
        out_q       <= QNAN;
        out_flags   <= to_flags;
        out_timeout <= 1'b1;
      end
    end
  end

endmodule
